// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU load/store port, the peripheral master and the
// single-ported data memory. The arbiter takes the slave view; the environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic [WIDTH-1:0]  cpu_rdata;
    logic              cpu_ack;

    logic              dev_req;
    logic              dev_we;
    logic [ADDR_W-1:0] dev_adr;
    logic [WIDTH-1:0]  dev_wdata;
    logic [WIDTH-1:0]  dev_rdata;
    logic              dev_ack;
    logic              dev_err;

    logic [ADDR_W-1:0] mem_adr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dev_req, dev_we, dev_adr, dev_wdata,
        output dev_rdata, dev_ack, dev_err,
        output mem_adr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dev_req, dev_we, dev_adr, dev_wdata,
        input  dev_rdata, dev_ack, dev_err,
        input  mem_adr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between the CPU and a
// peripheral master; peripheral writes into the protected low region are dropped and flagged.
module mem_port_arbiter #(
    parameter int                WIDTH      = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 16'h5FFF
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_last_dev;
    logic               r_owner_dev;
    logic               r_blocked;
    logic [ADDR_W-1:0]  r_adr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_mem_we;
    logic               r_cpu_ack;
    logic               r_dev_ack;
    logic               r_dev_err;
    logic               r_busy;

    logic               w_any_req;
    logic               w_pick_dev;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_adr;
    logic [WIDTH-1:0]   w_sel_wdata;
    logic               w_block;

    // Under a tie the requester that did not win last time takes the grant.
    always_comb begin
        w_any_req   = bus.cpu_req | bus.dev_req;
        w_pick_dev  = bus.dev_req & (~bus.cpu_req | ~r_last_dev);
        w_sel_we    = w_pick_dev ? bus.dev_we    : bus.cpu_we;
        w_sel_adr   = w_pick_dev ? bus.dev_adr   : bus.cpu_adr;
        w_sel_wdata = w_pick_dev ? bus.dev_wdata : bus.cpu_wdata;
        w_block     = w_pick_dev & bus.dev_we & (bus.dev_adr <= PROT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_dev  <= 1'b1;
            r_owner_dev <= 1'b0;
            r_blocked   <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dev_ack   <= 1'b0;
            r_dev_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dev_ack <= 1'b0;
            r_dev_err <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_any_req) begin
                        r_state     <= S_ACCESS;
                        r_owner_dev <= w_pick_dev;
                        r_last_dev  <= w_pick_dev;
                        r_blocked   <= w_block;
                        r_adr       <= w_sel_adr;
                        r_wdata     <= w_sel_wdata;
                        r_mem_we    <= w_sel_we & ~w_block;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    r_state   <= S_RESP;
                    r_cpu_ack <= ~r_owner_dev;
                    r_dev_ack <= r_owner_dev;
                    r_dev_err <= r_blocked;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Address/data registers are loaded at grant, so they drive memory during ACCESS and hold afterwards.
    assign bus.mem_adr   = r_adr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dev_ack   = r_dev_ack;
    assign bus.dev_err   = r_dev_err;
    assign bus.busy      = r_busy;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dev_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// service order and read data; a negedge monitor pops and compares on every ack.
module tb_mem_port_arbiter;

    localparam logic [15:0] PROT = 16'h5FFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(16), .ADDR_W(16)) bus ();

    mem_port_arbiter #(.WIDTH(16), .ADDR_W(16), .PROT_LIMIT(16'h5FFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous memory macro: registered read, one cycle after address.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_adr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: shadow memory, last-grant bit, expected-response queue.
    typedef struct {
        bit          dev;
        bit          we;
        bit          err;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [int unsigned];
    bit          m_last_dev = 1'b1;

    task automatic model_txn(input bit dev, input bit we, input logic [15:0] adr, input logic [15:0] wd);
        exp_t e;
        e.dev  = dev;
        e.we   = we;
        e.err  = dev && we && (adr <= PROT);
        e.data = '0;
        if (!we) e.data = ref_mem.exists(32'(adr)) ? ref_mem[32'(adr)] : 16'h0;
        else if (!e.err) ref_mem[32'(adr)] = wd;
        sb.push_back(e);
        m_last_dev = dev;
    endtask

    // Monitor
    bit alt_en = 0, alt_have = 0, alt_dev = 0;
    int alt_cyc = 0;
    exp_t me;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cpu_ack || bus.dev_ack) begin
                chk("ack_exclusive", {31'd0, bus.cpu_ack & bus.dev_ack}, 0);
                if (sb.size() == 0) begin
                    chk("ack_with_empty_scoreboard", {30'd0, bus.cpu_ack, bus.dev_ack}, 0);
                end else begin
                    me = sb.pop_front();
                    chk("ack_port_is_dev", {31'd0, bus.dev_ack}, {31'd0, me.dev});
                    if (!me.we) chk("rdata", bus.dev_ack ? bus.dev_rdata : bus.cpu_rdata, me.data);
                    chk("dev_err", {31'd0, bus.dev_err}, {31'd0, me.err});
                end
                if (alt_en) begin
                    if (alt_have) begin
                        chk("contention_spacing", cyc - alt_cyc, 2);
                        chk("contention_alternates", {31'd0, bus.dev_ack}, {31'd0, !alt_dev});
                    end
                    alt_have = 1;
                    alt_cyc  = cyc;
                    alt_dev  = bus.dev_ack;
                end
            end else if (bus.dev_err) begin
                chk("dev_err_without_ack", {31'd0, bus.dev_err}, 0);
            end
        end
    end

    // One round: requested transactions are pushed in predicted service order,
    // then driven; each requester drops req in its own ack cycle.
    task automatic run_round(input bit uc, input bit ud,
                             input bit cwe, input logic [15:0] cadr, input logic [15:0] cwd,
                             input bit dwe, input logic [15:0] dadr, input logic [15:0] dwd,
                             output int clat, output int dlat, output int wecnt,
                             output logic [15:0] adr1);
        int pending;
        if (uc && ud) begin
            if (m_last_dev) begin
                model_txn(0, cwe, cadr, cwd); model_txn(1, dwe, dadr, dwd);
            end else begin
                model_txn(1, dwe, dadr, dwd); model_txn(0, cwe, cadr, cwd);
            end
        end else if (uc) model_txn(0, cwe, cadr, cwd);
        else if (ud) model_txn(1, dwe, dadr, dwd);
        bus.cpu_req = uc; bus.cpu_we = cwe; bus.cpu_adr = cadr; bus.cpu_wdata = cwd;
        bus.dev_req = ud; bus.dev_we = dwe; bus.dev_adr = dadr; bus.dev_wdata = dwd;
        clat = -1; dlat = -1; wecnt = 0; adr1 = '0;
        pending = int'(uc) + int'(ud);
        for (int i = 1; i <= 20 && pending > 0; i++) begin
            @(negedge clk);
            if (i == 1) adr1 = bus.mem_adr;
            if (bus.mem_we) wecnt++;
            if (bus.cpu_ack && bus.cpu_req) begin bus.cpu_req = 0; clat = i; pending--; end
            if (bus.dev_ack && bus.dev_req) begin bus.dev_req = 0; dlat = i; pending--; end
        end
        if (pending > 0) begin
            chk("round_timeout_pending", pending, 0);
            bus.cpu_req = 0; bus.dev_req = 0;
        end
    endtask

    task automatic wait_cpu_ack(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin n = i; break; end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] atab [8];
        int cl, dl, wc, t1, t2, nack;
        logic [15:0] a1;
        atab = '{16'h0000, 16'h0010, 16'h5FFE, 16'h5FFF, 16'h6000, 16'h6001, 16'h7000, 16'hFFFF};

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.dev_req = 0; bus.dev_we = 0; bus.dev_adr = '0; bus.dev_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 0;

        chk("reset_cpu_ack", {31'd0, bus.cpu_ack}, 0);
        chk("reset_dev_ack", {31'd0, bus.dev_ack}, 0);
        chk("reset_dev_err", {31'd0, bus.dev_err}, 0);
        chk("reset_mem_we", {31'd0, bus.mem_we}, 0);
        chk("reset_mem_adr", bus.mem_adr, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        chk("reset_busy", {31'd0, bus.busy}, 0);

        // First tie after reset: CPU write, then dev read sees it.
        run_round(1, 1, 1, 16'h7000, 16'h1234, 0, 16'h7000, 16'h0000, cl, dl, wc, a1);
        chk("tie_cpu_ack_latency", cl, 2);
        chk("tie_dev_ack_latency", dl, 4);

        // Preload every address the random phase uses.
        foreach (atab[k]) begin
            run_round(1, 0, 1, atab[k], (atab[k] == 16'h6000) ? 16'hBEEF : 16'(k * 16'h1111 + 16'h0101),
                      0, 16'h0, 16'h0, cl, dl, wc, a1);
        end

        run_round(1, 0, 0, 16'h6000, 16'h0, 0, 16'h0, 16'h0, cl, dl, wc, a1);
        chk("cpu_read_mem_adr_access", a1, 16'h6000);
        chk("cpu_read_ack_latency", cl, 2);
        chk("cpu_read_no_dev_ack", dl, -1);

        // Protection boundary.
        run_round(0, 1, 0, 16'h0, 16'h0, 1, 16'h5FFF, 16'hFFFF, cl, dl, wc, a1);
        chk("blocked_write_mem_we_cycles", wc, 0);
        run_round(0, 1, 0, 16'h0, 16'h0, 0, 16'h5FFF, 16'h0, cl, dl, wc, a1);
        run_round(0, 1, 0, 16'h0, 16'h0, 1, 16'h6000, 16'h1357, cl, dl, wc, a1);
        chk("dev_write_6000_mem_we_cycles", wc, 1);
        run_round(1, 0, 1, 16'h0010, 16'h2468, 0, 16'h0, 16'h0, cl, dl, wc, a1);
        chk("cpu_write_0010_mem_we_cycles", wc, 1);
        run_round(0, 1, 0, 16'h0, 16'h0, 0, 16'h0010, 16'h0, cl, dl, wc, a1);

        // Inputs changed after grant must not alter the latched write.
        model_txn(0, 1, 16'h6001, 16'hA5A5);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 16'h6001; bus.cpu_wdata = 16'hA5A5;
        @(negedge clk);
        bus.cpu_adr = 16'h7000; bus.cpu_wdata = 16'h0000;
        wait_cpu_ack(cl);
        bus.cpu_req = 0;
        chk("post_grant_change_ack_latency", cl, 1);
        run_round(1, 0, 0, 16'h6001, 16'h0, 0, 16'h0, 16'h0, cl, dl, wc, a1);
        run_round(1, 0, 0, 16'h7000, 16'h0, 0, 16'h0, 16'h0, cl, dl, wc, a1);

        // Back-to-back CPU reads.
        model_txn(0, 0, 16'h6000, 16'h0);
        model_txn(0, 0, 16'h7000, 16'h0);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 16'h6000;
        wait_cpu_ack(t1);
        bus.cpu_adr = 16'h7000;
        wait_cpu_ack(t2);
        bus.cpu_req = 0;
        chk("back_to_back_spacing", t2, 2);

        // Sustained contention: ten acks, strictly alternating.
        for (int k = 0; k < 10; k++) begin
            if (m_last_dev) model_txn(0, 0, 16'h6000, 16'h0);
            else            model_txn(1, 0, 16'h7000, 16'h0);
        end
        alt_en = 1; alt_have = 0; nack = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 16'h6000;
        bus.dev_req = 1; bus.dev_we = 0; bus.dev_adr = 16'h7000;
        for (int i = 0; i < 40 && nack < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dev_ack) nack++;
        end
        bus.cpu_req = 0; bus.dev_req = 0;
        alt_en = 0;
        chk("contention_ack_count", nack, 10);

        // Reset during ACCESS of a dev read.
        @(negedge clk);
        bus.dev_req = 1; bus.dev_we = 0; bus.dev_adr = 16'h6000;
        @(negedge clk);
        chk("abort_busy_in_access", {31'd0, bus.busy}, 1);
        reset = 1; bus.dev_req = 0;
        @(negedge clk);
        chk("abort_dev_ack", {31'd0, bus.dev_ack}, 0);
        chk("abort_cpu_ack", {31'd0, bus.cpu_ack}, 0);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_mem_we", {31'd0, bus.mem_we}, 0);
        chk("abort_dev_err", {31'd0, bus.dev_err}, 0);
        reset = 0;
        m_last_dev = 1'b1;
        run_round(1, 1, 0, 16'h6000, 16'h0, 0, 16'h6001, 16'h0, cl, dl, wc, a1);
        chk("post_reset_tie_cpu_first", cl, 2);
        chk("post_reset_tie_dev_second", dl, 4);

        // Randomized rounds.
        for (int r = 0; r < 150; r++) begin
            int unsigned pat;
            pat = $urandom_range(1, 3);
            run_round(pat[0], pat[1],
                      1'($urandom_range(0, 1)), atab[$urandom_range(0, 7)], 16'($urandom),
                      1'($urandom_range(0, 1)), atab[$urandom_range(0, 7)], 16'($urandom),
                      cl, dl, wc, a1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
